// File: rtl/gray_step_tracker.sv
// gray_step_tracker
//   Accepts Gray-coded samples over valid/ready, converts each to binary,
//   reports the modular signed step from the previous sample and flags any
//   step that changes more than one Gray bit. An illegal step halts intake
//   until clear_err restarts tracking.
//   Optional feature macro: GRAY_TRACK_ACCUM_EN adds a saturating signed
//   accumulator of legal steps on port accum.
module gray_step_tracker #(
    parameter int DATAWIDTH = 4
`ifdef GRAY_TRACK_ACCUM_EN
    , parameter int ACCWIDTH = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] data_in,
    input  logic                 clear_err,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] data_out,
    output logic [DATAWIDTH-1:0] delta,
    output logic                 first,
    output logic                 step_err,
    output logic                 err_sticky
`ifdef GRAY_TRACK_ACCUM_EN
    , output logic [ACCWIDTH-1:0] accum
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_TRACK = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [DATAWIDTH-1:0] ONE  = {{(DATAWIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATAWIDTH-1:0] ZERO = {DATAWIDTH{1'b0}};

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [DATAWIDTH-1:0] gray2bin(input logic [DATAWIDTH-1:0] g);
        logic [DATAWIDTH-1:0] b;
        b[DATAWIDTH-1] = g[DATAWIDTH-1];
        for (int i = DATAWIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // True when at most one bit is set (a legal Gray transition mask).
    function automatic logic at_most_one_bit(input logic [DATAWIDTH-1:0] x);
        return ((x & (x - ONE)) == ZERO);
    endfunction

    state_t               state_q, state_d;
    logic                 out_valid_q, out_valid_d;
    logic [DATAWIDTH-1:0] data_out_q, data_out_d;
    logic [DATAWIDTH-1:0] delta_q, delta_d;
    logic                 first_q, first_d;
    logic                 step_err_q, step_err_d;
    logic                 err_sticky_q, err_sticky_d;
    logic [DATAWIDTH-1:0] gray_prev_q, gray_prev_d;
    logic [DATAWIDTH-1:0] bin_prev_q, bin_prev_d;

    logic                 in_ready_s;
    logic                 accept_s;
    logic                 take_first_s;
    logic                 legal_s;
    logic [DATAWIDTH-1:0] bin_new_s;
    logic [DATAWIDTH-1:0] step_s;

`ifdef GRAY_TRACK_ACCUM_EN
    localparam logic [ACCWIDTH-1:0] ACC_MAX = {1'b0, {(ACCWIDTH-1){1'b1}}};
    localparam logic [ACCWIDTH-1:0] ACC_MIN = {1'b1, {(ACCWIDTH-1){1'b0}}};
    logic [ACCWIDTH-1:0] accum_q, accum_d;
    logic [ACCWIDTH:0]   acc_sum_s;
    assign accum = accum_q;
`endif

    assign in_ready_s = !rst && (state_q != ST_HALT) && (!out_valid_q || out_ready);
    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_q;
    assign data_out   = data_out_q;
    assign delta      = delta_q;
    assign first      = first_q;
    assign step_err   = step_err_q;
    assign err_sticky = err_sticky_q;

    // Next-state decode: handshake, conversion, legality check and FSM transitions.
    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        data_out_d   = data_out_q;
        delta_d      = delta_q;
        first_d      = first_q;
        step_err_d   = step_err_q;
        err_sticky_d = err_sticky_q;
        gray_prev_d  = gray_prev_q;
        bin_prev_d   = bin_prev_q;

        accept_s     = in_valid && in_ready_s;
        bin_new_s    = gray2bin(data_in);
        step_s       = bin_new_s - bin_prev_q;
        legal_s      = at_most_one_bit(data_in ^ gray_prev_q);
        // A clear in the same cycle as an accept restarts tracking with this sample.
        take_first_s = clear_err || (state_q == ST_EMPTY);

`ifdef GRAY_TRACK_ACCUM_EN
        accum_d   = accum_q;
        acc_sum_s = {accum_q[ACCWIDTH-1], accum_q} + (ACCWIDTH+1)'($signed(step_s));
`endif

        if (clear_err) begin
            err_sticky_d = 1'b0;
        end else begin
            err_sticky_d = err_sticky_q;
        end

        if (accept_s) begin
            out_valid_d = 1'b1;
            data_out_d  = bin_new_s;
            if (take_first_s) begin
                first_d     = 1'b1;
                delta_d     = ZERO;
                step_err_d  = 1'b0;
                gray_prev_d = data_in;
                bin_prev_d  = bin_new_s;
                state_d     = ST_TRACK;
            end else if (legal_s) begin
                first_d     = 1'b0;
                delta_d     = step_s;
                step_err_d  = 1'b0;
                gray_prev_d = data_in;
                bin_prev_d  = bin_new_s;
                state_d     = ST_TRACK;
`ifdef GRAY_TRACK_ACCUM_EN
                if (acc_sum_s[ACCWIDTH] != acc_sum_s[ACCWIDTH-1]) begin
                    accum_d = acc_sum_s[ACCWIDTH] ? ACC_MIN : ACC_MAX;
                end else begin
                    accum_d = acc_sum_s[ACCWIDTH-1:0];
                end
`endif
            end else begin
                // Illegal step: report it but keep the last good reference.
                first_d      = 1'b0;
                delta_d      = step_s;
                step_err_d   = 1'b1;
                err_sticky_d = 1'b1;
                state_d      = ST_HALT;
            end
        end else begin
            if (out_ready) begin
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = out_valid_q;
            end
            if (clear_err) begin
                state_d = ST_EMPTY;
            end else begin
                state_d = state_q;
            end
        end
    end

    // State, reference and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            out_valid_q  <= 1'b0;
            data_out_q   <= ZERO;
            delta_q      <= ZERO;
            first_q      <= 1'b0;
            step_err_q   <= 1'b0;
            err_sticky_q <= 1'b0;
            gray_prev_q  <= ZERO;
            bin_prev_q   <= ZERO;
`ifdef GRAY_TRACK_ACCUM_EN
            accum_q      <= {ACCWIDTH{1'b0}};
`endif
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            data_out_q   <= data_out_d;
            delta_q      <= delta_d;
            first_q      <= first_d;
            step_err_q   <= step_err_d;
            err_sticky_q <= err_sticky_d;
            gray_prev_q  <= gray_prev_d;
            bin_prev_q   <= bin_prev_d;
`ifdef GRAY_TRACK_ACCUM_EN
            accum_q      <= accum_d;
`endif
        end
    end

endmodule

// File: tb/tb_gray_step_tracker.sv
// Scoreboard bench for gray_step_tracker (DATAWIDTH=4): directed scenarios
// followed by randomized traffic against a behavioural model.
module tb_gray_step_tracker;

    localparam int N    = 4;
    localparam int MASK = 15;
`ifdef GRAY_TRACK_ACCUM_EN
    localparam int AW   = 4;
    logic [AW-1:0] accum;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] data_in = '0;
    logic         clear_err = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] data_out;
    logic [N-1:0] delta;
    logic         first;
    logic         step_err;
    logic         err_sticky;

    gray_step_tracker #(
        .DATAWIDTH(N)
`ifdef GRAY_TRACK_ACCUM_EN
        , .ACCWIDTH(AW)
`endif
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .clear_err(clear_err), .out_valid(out_valid),
        .out_ready(out_ready), .data_out(data_out), .delta(delta),
        .first(first), .step_err(step_err), .err_sticky(err_sticky)
`ifdef GRAY_TRACK_ACCUM_EN
        , .accum(accum)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int bin;
        int dlt;
        bit frst;
        bit err;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;

    // Behavioural model state (values after the most recent clock edge).
    bit m_ov = 0, m_halt = 0, m_have = 0, m_sticky = 0;
    int m_pgray = 0, m_pbin = 0, m_acc = 0;

    function automatic int g2b(int g);
        int b = 0;
        for (int s = 0; s < N; s++) b = b ^ (g >> s);
        return b & MASK;
    endfunction

    task automatic check(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus plus model update.
    task automatic cyc(bit v, int d, bit cl, bit ordy, bit r);
        bit exp_ir, acc, push;
        exp_t e;
        bit n_ov, n_halt, n_have, n_sticky;
        int n_pg, n_pb, n_acc, nb, ds, lim;
        @(negedge clk);
        rst = r; in_valid = v; data_in = d[3:0]; clear_err = cl; out_ready = ordy;
        #1;
        exp_ir = !r && !m_halt && (!m_ov || ordy);
        check("in_ready", in_ready, exp_ir);
        acc = v && exp_ir;
        n_ov = m_ov; n_halt = m_halt; n_have = m_have; n_sticky = m_sticky;
        n_pg = m_pgray; n_pb = m_pbin; n_acc = m_acc; push = 0;
        e = '{bin: 0, dlt: 0, frst: 0, err: 0};
        if (r) begin
            n_ov = 0; n_halt = 0; n_have = 0; n_sticky = 0;
            n_pg = 0; n_pb = 0; n_acc = 0;
        end else begin
            if (cl) begin n_sticky = 0; n_halt = 0; n_have = 0; end
            if (acc) begin
                nb = g2b(d); e.bin = nb; n_ov = 1; push = 1;
                if (!n_have) begin
                    e.frst = 1; n_have = 1; n_pg = d; n_pb = nb;
                end else if ($countones((d ^ m_pgray) & MASK) <= 1) begin
                    e.dlt = (nb - m_pbin) & MASK; n_pg = d; n_pb = nb;
                    ds = (e.dlt >= 8) ? e.dlt - 16 : e.dlt;
`ifdef GRAY_TRACK_ACCUM_EN
                    lim = 1 << (AW - 1);
`else
                    lim = 1 << 15;
`endif
                    n_acc = m_acc + ds;
                    if (n_acc > lim - 1) n_acc = lim - 1;
                    if (n_acc < -lim) n_acc = -lim;
                end else begin
                    e.err = 1; n_sticky = 1; n_halt = 1;
                end
            end else if (ordy) begin
                n_ov = 0;
            end
        end
        @(posedge clk);
        #1;
        m_ov = n_ov; m_halt = n_halt; m_have = n_have; m_sticky = n_sticky;
        m_pgray = n_pg; m_pbin = n_pb; m_acc = n_acc;
        if (r) begin
            q.delete();
            check("rst_outputs", {out_valid, data_out, delta, first, step_err, err_sticky}, 0);
        end
        if (push) q.push_back(e);
    endtask

    // Monitor: per-cycle status checks and scoreboard pop on each output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                check("out_valid", out_valid, m_ov);
                check("err_sticky", err_sticky, m_sticky);
`ifdef GRAY_TRACK_ACCUM_EN
                check("accum", int'($signed(accum)), m_acc);
`endif
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        check("unexpected_result", 1, 0);
                    end else begin
                        e = q.pop_front();
                        check("data_out", data_out, e.bin);
                        check("first", first, e.frst);
                        check("step_err", step_err, e.err);
                        if (!e.err) check("delta", delta, e.dlt);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 0);
    endtask

    initial begin
        int g, mode;
        do_reset();
        mon_en = 1'b1;

        // Incrementing and decrementing single-bit steps.
        cyc(1, 0, 0, 1, 0); cyc(1, 1, 0, 1, 0); cyc(1, 3, 0, 1, 0); cyc(1, 1, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);

        // Wrap-around both directions.
        do_reset();
        cyc(1, 0, 0, 1, 0); cyc(1, 8, 0, 1, 0); cyc(1, 0, 0, 1, 0); cyc(0, 0, 0, 1, 0);

        // Illegal step, halt, clear, restart.
        do_reset();
        cyc(1, 0, 0, 1, 0); cyc(1, 3, 0, 1, 0); cyc(1, 6, 0, 1, 0);
        cyc(0, 0, 1, 1, 0); cyc(1, 6, 0, 1, 0); cyc(0, 0, 0, 1, 0);

        // Backpressure holds the result and blocks the next sample.
        do_reset();
        cyc(1, 0, 0, 1, 0); cyc(1, 1, 0, 1, 0);
        cyc(1, 3, 0, 0, 0); cyc(1, 3, 0, 0, 0); cyc(1, 3, 0, 0, 0);
        cyc(1, 3, 0, 1, 0); cyc(0, 0, 0, 1, 0);

        // Reset with a result pending, then first sample again.
        cyc(1, 2, 0, 0, 0); cyc(0, 0, 0, 1, 1); cyc(1, 2, 0, 1, 0); cyc(0, 0, 0, 1, 0);

        // Long ramp of +1 steps (saturates the accumulator when enabled), then -1.
        do_reset();
        cyc(1, 0, 0, 1, 0);
        for (int i = 1; i <= 10; i++) cyc(1, i ^ (i >> 1), 0, 1, 0);
        cyc(1, 9 ^ (9 >> 1), 0, 1, 0);
        cyc(0, 0, 0, 1, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            mode = $urandom_range(0, 99);
            if (mode < 60)      g = m_pgray ^ (1 << $urandom_range(0, N - 1));
            else if (mode < 75) g = m_pgray;
            else                g = $urandom_range(0, MASK);
            cyc(($urandom_range(0, 3) != 0), g, ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0));
        end
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
